// File: rtl/can_tx_scheduler.sv
// rtl/can_tx_scheduler.sv - CAN transmit mailbox scheduler: lowest-ID arbitration, retry and abort handling
//
// Ports:
//   i_Clock, i_Reset        clock and asynchronous active-high reset
//   i_Req[N_MBOX]           per-mailbox pending-frame level
//   i_Id[N_MBOX*ID_W]       packed identifiers, mailbox m at [m*ID_W +: ID_W]
//   i_Bus_Idle              bus idle / interframe space complete
//   i_Tx_Done, i_Arb_Lost, i_Tx_Error   one-cycle result pulses from the transmitter
//   o_Tx_Start, o_Tx_Sel    start pulse and index of the granted mailbox
//   o_Grant                 one-hot grant held for the attempt
//   o_Done, o_Abort         per-mailbox one-cycle completion / retry-limit pulses
//   o_Busy                  high whenever the scheduler is not idle
module can_tx_scheduler #(
    parameter int N_MBOX      = 4,
    parameter int ID_W        = 11,
    parameter int MAX_RETRY   = 8,
    parameter int TIMEOUT_CYC = 4096,
    localparam int SEL_W      = (N_MBOX > 1) ? $clog2(N_MBOX) : 1,
    localparam int TO_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic [N_MBOX-1:0]      i_Req,
    input  logic [N_MBOX*ID_W-1:0] i_Id,
    input  logic                   i_Bus_Idle,
    input  logic                   i_Tx_Done,
    input  logic                   i_Arb_Lost,
    input  logic                   i_Tx_Error,
    output logic                   o_Tx_Start,
    output logic [SEL_W-1:0]       o_Tx_Sel,
    output logic [N_MBOX-1:0]      o_Grant,
    output logic [N_MBOX-1:0]      o_Done,
    output logic [N_MBOX-1:0]      o_Abort,
    output logic                   o_Busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    w_sel_nxt;
    logic [N_MBOX-1:0]   r_grant;
    logic [N_MBOX-1:0]   w_grant_nxt;
    logic [N_MBOX-1:0]   r_done;
    logic [N_MBOX-1:0]   w_done_nxt;
    logic [N_MBOX-1:0]   r_abort;
    logic [N_MBOX-1:0]   w_abort_nxt;
    logic [3:0]          r_retry [N_MBOX];
    logic [TO_W-1:0]     r_timeout;

    logic                w_win_found;
    logic [SEL_W-1:0]    w_win_idx;
    logic [ID_W-1:0]     w_win_id;
    logic [3:0]          w_retry_cur;
    logic [3:0]          w_retry_new;
    logic                w_timeout_hit;
    logic                w_retry_inc;
    logic                w_retry_clr;
    logic                w_to_clr;

    // Lowest identifier among requesting mailboxes. Strict less-than while
    // scanning upward means an equal ID never displaces a lower index.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_win_id    = '0;
        for (int m = 0; m < N_MBOX; m++) begin
            if (i_Req[m] && (!w_win_found || (i_Id[m*ID_W +: ID_W] < w_win_id))) begin
                w_win_found = 1'b1;
                w_win_idx   = SEL_W'(m);
                w_win_id    = i_Id[m*ID_W +: ID_W];
            end
        end
    end

    assign w_retry_cur   = r_retry[r_sel];
    // Saturating increment; the counter is cleared on reaching the limit so
    // saturation only guards against an out-of-range parameter.
    assign w_retry_new   = (w_retry_cur >= 4'(MAX_RETRY)) ? w_retry_cur : w_retry_cur + 4'd1;
    assign w_timeout_hit = (r_timeout == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;
        w_abort_nxt = '0;
        w_retry_inc = 1'b0;
        w_retry_clr = 1'b0;
        w_to_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_Bus_Idle && (|i_Req)) begin
                    w_state_nxt = S_ARB;
                end
            end
            S_ARB: begin
                if (w_win_found) begin
                    w_sel_nxt   = w_win_idx;
                    w_grant_nxt = N_MBOX'(1) << w_win_idx;
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                w_to_clr    = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Error (or timeout) outranks arbitration loss, which outranks done.
                if (i_Tx_Error || w_timeout_hit) begin
                    w_grant_nxt = '0;
                    if (w_retry_new == 4'(MAX_RETRY)) begin
                        w_abort_nxt = r_grant;
                        w_retry_clr = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_retry_inc = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (i_Arb_Lost) begin
                    w_grant_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else if (i_Tx_Done) begin
                    w_grant_nxt = '0;
                    w_done_nxt  = r_grant;
                    w_retry_clr = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                // Lets the mailbox drop its request before IDLE samples it again.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_sel     <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_abort   <= '0;
            r_timeout <= '0;
            for (int m = 0; m < N_MBOX; m++) begin
                r_retry[m] <= '0;
            end
        end else begin
            r_sel   <= w_sel_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_abort <= w_abort_nxt;
            if (w_to_clr) begin
                r_timeout <= '0;
            end else if ((r_state == S_WAIT) && !w_timeout_hit) begin
                r_timeout <= r_timeout + TO_W'(1);
            end
            if (w_retry_clr) begin
                r_retry[r_sel] <= '0;
            end else if (w_retry_inc) begin
                r_retry[r_sel] <= w_retry_new;
            end
        end
    end

    assign o_Tx_Start = (r_state == S_START);
    assign o_Tx_Sel   = r_sel;
    assign o_Grant    = r_grant;
    assign o_Done     = r_done;
    assign o_Abort    = r_abort;
    assign o_Busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_can_tx_scheduler.sv
// tb/tb_can_tx_scheduler.sv - self-checking bench for can_tx_scheduler
module tb_can_tx_scheduler;

    localparam int N_MBOX  = 4;
    localparam int ID_W    = 11;
    localparam int MAX_R   = 3;
    localparam int TIMEOUT = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_MBOX-1:0]      req;
    logic [N_MBOX*ID_W-1:0] id;
    logic                   bus_idle, tx_done, arb_lost, tx_error;
    logic                   tx_start, busy;
    logic [1:0]             tx_sel;
    logic [N_MBOX-1:0]      grant, done, abort_o;

    int n_checks = 0;
    int n_fail   = 0;

    can_tx_scheduler #(
        .N_MBOX(N_MBOX), .ID_W(ID_W), .MAX_RETRY(MAX_R), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Req(req), .i_Id(id),
        .i_Bus_Idle(bus_idle), .i_Tx_Done(tx_done), .i_Arb_Lost(arb_lost),
        .i_Tx_Error(tx_error), .o_Tx_Start(tx_start), .o_Tx_Sel(tx_sel),
        .o_Grant(grant), .o_Done(done), .o_Abort(abort_o), .o_Busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [10:0] id0, id1, id2, id3;
        logic [1:0]  exp_sel;
        logic [3:0]  exp_grant;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From IDLE with requests set and bus idle: ARB, START, then into the first WAIT cycle.
    task automatic attempt(input string name, input logic [1:0] esel, input logic [3:0] egrant);
        step();
        chk({name, "_arb_busy"}, 32'(busy), 32'd1);
        chk({name, "_arb_nostart"}, 32'(tx_start), 32'd0);
        step();
        chk({name, "_start"}, 32'(tx_start), 32'd1);
        chk({name, "_sel"}, 32'(tx_sel), 32'(esel));
        chk({name, "_grant"}, 32'(grant), 32'(egrant));
        step();
        chk({name, "_wait_nostart"}, 32'(tx_start), 32'd0);
        chk({name, "_wait_grant"}, 32'(grant), 32'(egrant));
    endtask

    task automatic pulse_err(input string name, input logic [3:0] eabort);
        tx_error = 1'b1;
        step();
        tx_error = 1'b0;
        chk({name, "_abort"}, 32'(abort_o), 32'(eabort));
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_grant0"}, 32'(grant), 32'd0);
    endtask

    initial begin
        vecs[0] = '{4'b1011, 11'h200, 11'h123, 11'h001, 11'h050, 2'd3, 4'b1000};
        vecs[1] = '{4'b0110, 11'h7FF, 11'h100, 11'h100, 11'h000, 2'd1, 4'b0010};
        vecs[2] = '{4'b0001, 11'h7FF, 11'h000, 11'h000, 11'h000, 2'd0, 4'b0001};
        vecs[3] = '{4'b1111, 11'h7FF, 11'h7FF, 11'h7FE, 11'h7FF, 2'd2, 4'b0100};
        vecs[4] = '{4'b1100, 11'h000, 11'h000, 11'h000, 11'h000, 2'd2, 4'b0100};
        vecs[5] = '{4'b1000, 11'h000, 11'h001, 11'h002, 11'h3AB, 2'd3, 4'b1000};

        rst = 1'b1; req = '0; id = '0; bus_idle = 1'b0;
        tx_done = 1'b0; arb_lost = 1'b0; tx_error = 1'b0;
        step(); step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_sel", 32'(tx_sel), 32'd0);
        rst = 1'b0;
        step();

        // Arbitration vectors, each ending in a successful transmission.
        for (int v = 0; v < 6; v++) begin
            req = vecs[v].req;
            id = {vecs[v].id3, vecs[v].id2, vecs[v].id1, vecs[v].id0};
            bus_idle = 1'b1;
            attempt($sformatf("vec%0d", v), vecs[v].exp_sel, vecs[v].exp_grant);
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            chk($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].exp_grant));
            chk($sformatf("vec%0d_hold_grant", v), 32'(grant), 32'd0);
            chk($sformatf("vec%0d_hold_busy", v), 32'(busy), 32'd1);
            req = '0;
            step();
            chk($sformatf("vec%0d_idle", v), 32'(busy), 32'd0);
            chk($sformatf("vec%0d_done_clr", v), 32'(done), 32'd0);
        end

        // Arbitration loss: m0 loses, m2 (ID 0x010) appears and wins, then m0
        // resumes with retry count untouched (abort only on its third error).
        req = 4'b0001; id = {11'h000, 11'h010, 11'h000, 11'h200}; bus_idle = 1'b1;
        attempt("al_m0", 2'd0, 4'b0001);
        arb_lost = 1'b1; req = 4'b0101;
        step();
        arb_lost = 1'b0;
        chk("al_idle", 32'(busy), 32'd0);
        chk("al_grant0", 32'(grant), 32'd0);
        attempt("al_m2", 2'd2, 4'b0100);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("al_m2_done", 32'(done), 32'b0100);
        req = 4'b0001;
        step();
        attempt("al_m0_r1", 2'd0, 4'b0001);
        pulse_err("al_err1", 4'b0000);
        chk("al_err1_idle", 32'(busy), 32'd0);
        attempt("al_m0_r2", 2'd0, 4'b0001);
        pulse_err("al_err2", 4'b0000);
        attempt("al_m0_r3", 2'd0, 4'b0001);
        pulse_err("al_err3", 4'b0001);
        req = '0;
        step();
        chk("al_after_abort", 32'(busy), 32'd0);

        // m1: coincident done+error, then timeout, then a plain error -> abort.
        req = 4'b0010; id = {11'h000, 11'h000, 11'h0AA, 11'h000};
        attempt("rl1", 2'd1, 4'b0010);
        tx_done = 1'b1; tx_error = 1'b1;
        step();
        tx_done = 1'b0; tx_error = 1'b0;
        chk("coinc_done", 32'(done), 32'd0);
        chk("coinc_idle", 32'(busy), 32'd0);
        attempt("rl2", 2'd1, 4'b0010);
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        chk("to_last_wait", 32'(busy), 32'd1);
        chk("to_last_grant", 32'(grant), 32'b0010);
        step();
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_abort", 32'(abort_o), 32'd0);
        attempt("rl3", 2'd1, 4'b0010);
        pulse_err("rl_err3", 4'b0010);
        chk("rl_hold_busy", 32'(busy), 32'd1);
        req = '0;
        step();
        chk("rl_idle", 32'(busy), 32'd0);
        chk("rl_abort_clr", 32'(abort_o), 32'd0);

        // Reset mid-WAIT clears outputs immediately; a later done is ignored.
        req = 4'b0100; id = {11'h000, 11'h055, 11'h000, 11'h000};
        attempt("rs", 2'd2, 4'b0100);
        rst = 1'b1;
        #1;
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_grant", 32'(grant), 32'd0);
        chk("rs_sel", 32'(tx_sel), 32'd0);
        bus_idle = 1'b0;
        #2;
        rst = 1'b0;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("rs_no_done", 32'(done), 32'd0);
        chk("rs_stay_idle", 32'(busy), 32'd0);
        step();
        chk("rs_no_done2", 32'(done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/can_tx_scheduler.md
# can_tx_scheduler

Transmit-side scheduler for the CAN node. It holds up to N_MBOX transmit mailbox requests and picks the one with the lowest identifier, i.e. the one that would win bus arbitration. It hands the winner to the bit-level transmitter, then handles the outcome: success, arbitration loss, error-frame retry, or abort. It sits between the mailbox register bank and the CAN transmitter, and takes bus-idle status from the receive path.

## Interface
Parameters:
- N_MBOX, 4, number of transmit mailboxes (2..8).
- ID_W, 11, identifier width compared for priority (11 standard, 29 extended).
- MAX_RETRY, 8, error-terminated attempts allowed per mailbox before abort (1..15).
- TIMEOUT_CYC, 4096, cycles in WAIT with no result before the attempt counts as an error.

Ports:
- i_Clock  in  1  system clock, all logic on rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Req  in  N_MBOX  level; bit m set means mailbox m has a frame pending.
- i_Id  in  N_MBOX*ID_W  packed identifiers; mailbox m occupies bits [m*ID_W +: ID_W].
- i_Bus_Idle  in  1  level from the receive path; 1 means the interframe space is complete and the bus is idle.
- i_Tx_Done  in  1  one-cycle pulse; frame acknowledged and EOF complete.
- i_Arb_Lost  in  1  one-cycle pulse; arbitration lost to another node.
- i_Tx_Error  in  1  one-cycle pulse; transmitter signalled an error frame.
- o_Tx_Start  out  1  one-cycle pulse commanding the transmitter to send mailbox o_Tx_Sel.
- o_Tx_Sel  out  clog2(N_MBOX)  index of the granted mailbox.
- o_Grant  out  N_MBOX  one-hot; held for the whole attempt, otherwise 0.
- o_Done  out  N_MBOX  one-cycle pulse on a mailbox's bit when its frame is sent.
- o_Abort  out  N_MBOX  one-cycle pulse on a mailbox's bit when it hits the retry limit.
- o_Busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ARB, START, WAIT, HOLD.
- IDLE
  - Go to ARB when i_Bus_Idle = 1 and i_Req is non-zero.
  - Otherwise stay in IDLE.
- ARB
  - Among the set bits of i_Req, select the mailbox with the numerically smallest i_Id. On an equal ID, the lowest index wins.
  - Register the winner into o_Tx_Sel and o_Grant, then go to START.
  - If i_Req is 0 in this cycle, return to IDLE with no grant.
- START
  - Drive o_Tx_Start = 1 for this cycle only, then go to WAIT.
- WAIT: the first matching rule applies.
  - i_Tx_Error, or timeout counter = TIMEOUT_CYC-1: increment retry[sel].
    - If the new count equals MAX_RETRY: pulse o_Abort[sel], clear retry[sel], go to HOLD.
    - Otherwise go to IDLE; the frame is re-arbitrated on the next idle bus.
  - i_Arb_Lost: retry[sel] is unchanged; go to IDLE.
  - i_Tx_Done: pulse o_Done[sel], clear retry[sel], go to HOLD.
- HOLD
  - One cycle in which o_Grant = 0, then go to IDLE.
  - The mailbox clears i_Req[sel] on the edge where o_Done or o_Abort is high. HOLD guarantees the stale request is never re-sampled.
- Priority when result pulses coincide: Error > Arb_Lost > Done.
- Request changes during WAIT are ignored; the attempt in flight is never cancelled. A withdrawn request still receives its o_Done or o_Abort.
- Per-mailbox retry counters are 4 bits and saturate at MAX_RETRY. The timeout counter is clog2(TIMEOUT_CYC) bits, cleared on entry to WAIT.
- o_Grant is cleared on leaving WAIT.

## Timing
- Reset (asynchronous, takes effect immediately, valid mid-frame):
  - state = IDLE.
  - o_Grant, o_Done, o_Abort, o_Tx_Start, o_Busy = 0; o_Tx_Sel = 0.
  - All retry and timeout counters = 0.
- Request latency: edge k samples IDLE conditions true. ARB occupies cycle k+1. o_Grant, o_Tx_Sel and o_Tx_Start are valid in cycle k+2. WAIT starts at cycle k+3.
- The ARB decision uses i_Req/i_Id sampled in cycle k+1, not cycle k.
- A result pulse in WAIT cycle j:
  - o_Done / o_Abort are high in cycle j+1 (the first HOLD cycle); the state reaches IDLE at j+2.
  - A retry after error or arbitration loss reaches IDLE at j+1.
- Minimum back-to-back spacing is 5 cycles from o_Tx_Start to o_Tx_Start, plus the frame time.
- Result pulses arriving outside WAIT are ignored.

## Test plan
- Reset mid-WAIT: i_Reset pulse -> all outputs 0 in the same cycle; no o_Done afterwards, even if i_Tx_Done follows.
- Priority: i_Req = 4'b1011, IDs {m0 = 0x200, m1 = 0x123, m3 = 0x050}, i_Bus_Idle = 1 -> o_Tx_Sel = 3, o_Grant = 4'b1000, o_Tx_Start 2 cycles after the IDLE sample. Then i_Tx_Done -> o_Done = 4'b1000.
- Equal IDs 0x100 on m1 and m2 -> m1 granted.
- Arbitration loss: grant m0, pulse i_Arb_Lost, raise a new m2 request with ID 0x010 -> next grant is m2, retry[m0] stays 0, m0 is sent afterwards.
- Retry limit: MAX_RETRY = 3, m1 gets i_Tx_Error three times -> third result gives o_Abort = 4'b0010, no o_Done, state returns to IDLE.
- Timeout and coincidence: no result for TIMEOUT_CYC cycles -> counted as an error and re-arbitrated. i_Tx_Done and i_Tx_Error in the same cycle -> error path taken, no o_Done.
